// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with optional write bypass, busy scoreboard and hardware clear sequencer
module regfile_param #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic            reg_write,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            ready
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t                state, state_nxt;
    logic                  ready_nxt;
    logic [AW-1:0]         clr_idx;
    logic [NREGS-1:0]      busy;
    logic [XLEN-1:0]       regs [NREGS];
    logic                  run, clr_last, wr_en, iss_en;
    assign run      = state == RUN;
    assign clr_last = clr_idx == AW'(NREGS - 1);
    assign wr_en    = reg_write && rd != '0;
    assign iss_en   = issue_valid && issue_rd != '0;
    always_comb begin
        state_nxt = state;
        ready_nxt = ready;
        if (state == CLEAR && clr_last) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            ready   <= 1'b0;
            clr_idx <= '0;
            busy    <= '0;
        end else begin
            state <= state_nxt;
            ready <= ready_nxt;
            if (state == CLEAR && !clr_last)
                clr_idx <= clr_idx + 1'b1;
            if (run) begin
                if (wr_en)
                    busy[rd] <= 1'b0;
                if (iss_en)
                    busy[issue_rd] <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                regs[clr_idx] <= '0;
            else if (wr_en)
                regs[rd] <= write_data;
        end
    end
    assign read_data1 = (!run || rs1 == '0) ? '0 :
                        (BYPASS != 0 && reg_write && rd == rs1) ? write_data : regs[rs1];
    assign read_data2 = (!run || rs2 == '0) ? '0 :
                        (BYPASS != 0 && reg_write && rd == rs2) ? write_data : regs[rs2];
    assign rs1_busy   = run && busy[rs1];
    assign rs2_busy   = run && busy[rs2];
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed self-checking bench for regfile_param (default build and a BYPASS=0 32x16 build)
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, issue_rd = '0;
    logic [63:0] write_data = '0;
    logic        reg_write = 1'b0, issue_valid = 1'b0;
    logic [63:0] read_data1, read_data2;
    logic        rs1_busy, rs2_busy, ready;
    logic [3:0]  rs1_b = '0, rs2_b = '0, rd_b = '0, issue_rd_b = '0;
    logic [31:0] write_data_b = '0;
    logic        reg_write_b = 1'b0, issue_valid_b = 1'b0;
    logic [31:0] read_data1_b, read_data2_b;
    logic        rs1_busy_b, rs2_busy_b, ready_b;
    int          n_checks = 0;
    int          n_fail = 0;

    regfile_param u_dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .write_data(write_data),
        .reg_write(reg_write), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .read_data1(read_data1), .read_data2(read_data2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .ready(ready)
    );

    regfile_param #(.XLEN(32), .NREGS(16), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .write_data(write_data_b),
        .reg_write(reg_write_b), .issue_valid(issue_valid_b), .issue_rd(issue_rd_b),
        .read_data1(read_data1_b), .read_data2(read_data2_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b), .ready(ready_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, nb;
        repeat (3) tick;
        check("reset_ready", ready, 0);
        check("reset_ready_b", ready_b, 0);
        check("reset_busy", rs1_busy, 0);
        check("reset_rd1", read_data1, 0);
        // release reset with a write and an issue to r4 pending through the whole clear
        rst = 1'b0; reg_write = 1'b1; rd = 5'd4; write_data = 64'hAA;
        issue_valid = 1'b1; issue_rd = 5'd4; rs1 = 5'd4;
        n = 0; nb = 0;
        while (!ready && n < 100) begin
            #1;
            if (n > 0) check("clear_rd1_zero", read_data1, 0);
            tick;
            n++;
            if (ready_b && nb == 0) nb = n;
        end
        check("clear_latency", n, 32);
        check("clear_latency_b", nb, 16);
        reg_write = 1'b0; issue_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check("post_clear_rd1", read_data1, 0);
            check("post_clear_busy", rs1_busy, 0);
        end
        // bypassed write, then stored value on port 2
        rd = 5'd5; write_data = 64'hDEAD_BEEF_0123_4567; reg_write = 1'b1; rs1 = 5'd5;
        #1;
        check("bypass_rd1", read_data1, 64'hDEAD_BEEF_0123_4567);
        tick;
        reg_write = 1'b0; rs2 = 5'd5;
        #1;
        check("stored_rd2", read_data2, 64'hDEAD_BEEF_0123_4567);
        rd = 5'd0; write_data = 64'hFF; reg_write = 1'b1; rs1 = 5'd0;
        #1;
        check("r0_bypass", read_data1, 0);
        tick;
        reg_write = 1'b0;
        #1;
        check("r0_stored", read_data1, 0);
        // BYPASS=0 build
        rd_b = 4'd3; write_data_b = 32'h1234_5678; reg_write_b = 1'b1; rs1_b = 4'd3;
        #1;
        check("nobypass_old", read_data1_b, 0);
        tick;
        reg_write_b = 1'b0;
        #1;
        check("nobypass_new", read_data1_b, 32'h1234_5678);
        // scoreboard
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        #1;
        check("issue_no_comb", rs1_busy, 0);
        tick;
        issue_valid = 1'b0;
        check("issue_busy", rs1_busy, 1);
        rd = 5'd7; write_data = 64'h77; reg_write = 1'b1;
        #1;
        check("busy_prewrite", rs1_busy, 1);
        check("busy_bypass_data", read_data1, 64'h77);
        tick;
        reg_write = 1'b0;
        check("write_clears_busy", rs1_busy, 0);
        rd = 5'd9; write_data = 64'h99; reg_write = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick;
        reg_write = 1'b0; issue_valid = 1'b0; rs1 = 5'd9; rs2 = 5'd9;
        #1;
        check("issue_wins_busy", rs2_busy, 1);
        check("issue_wins_data", read_data1, 64'h99);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick;
        issue_valid = 1'b0; rs1 = 5'd0;
        #1;
        check("r0_never_busy", rs1_busy, 0);
        // reset mid-operation
        rd = 5'd2; write_data = 64'h55; reg_write = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick;
        reg_write = 1'b0; issue_valid = 1'b0; rs1 = 5'd2; rs2 = 5'd6;
        #1;
        check("pre_rst_rd1", read_data1, 64'h55);
        check("pre_rst_busy", rs2_busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_ready_drop", ready, 0);
        n = 0;
        while (!ready && n < 100) begin
            tick;
            n++;
        end
        check("reclear_latency", n, 32);
        check("reclear_rd1", read_data1, 0);
        check("reclear_busy", rs2_busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
